fetch_pc_unit: RTL
==================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, width of the fetch PC in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset; asynchronous and active-low (0 = in reset).
REQ-004 SHALL have port stall, input, 1, hazard-unit freeze of the fetch PC.
REQ-005 SHALL have port redirect, input, 1, branch/jump taken (PcSel from the branch unit).
REQ-006 SHALL have port redirect_pc, input, 32, taken target (BrPC); bits above PC_W-1 ignored.
REQ-007 SHALL have port pc, output, PC_W, current fetch address.
REQ-008 SHALL have port pc_valid, output, 1, pc holds a fetchable address.
REQ-009 SHALL have port flush, output, 1, one-cycle pulse killing the IF/ID and ID/EX contents.
REQ-010 SHALL have port pending, output, 1, a redirect is captured and waiting for stall release.
REQ-011 SHALL have port misaligned, output, 1, one-cycle pulse: applied target had bits [1:0] != 0.

Function
REQ-012 SHALL implement a state machine with states BOOT, RUN, HOLD; all outputs registered.
REQ-013 BOOT: first rising edge after reset release SHALL go to RUN, set pc_valid=1, keep pc=0.
REQ-014 RUN, stall=0, redirect=0: pc SHALL advance by 4, wrapping modulo 2^PC_W.
REQ-015 RUN, stall=0, redirect=1: pc SHALL load {redirect_pc[PC_W-1:2],2'b00} next edge; flush=1 for that following cycle.
REQ-016 RUN, stall=1, redirect=0: pc SHALL hold; no flush.
REQ-017 RUN, stall=1, redirect=1: target SHALL be captured into a pending register; go HOLD; pc holds; pending=1 from next cycle.
REQ-018 HOLD, stall=1: pc and captured target SHALL hold; further redirect inputs ignored (first capture wins).
REQ-019 HOLD, stall=0: pc SHALL load captured target (low 2 bits cleared); flush=1 for one cycle; pending=0; go RUN; redirect input ignored on that edge.
REQ-020 misaligned SHALL pulse together with flush whenever the applied target had bits [1:0] != 0.
REQ-021 flush and misaligned SHALL never stay high more than one cycle per applied redirect; back-to-back redirects in RUN SHALL produce consecutive pulses.
REQ-022 Redirect with target equal to current pc SHALL still flush.

Reset
REQ-023 reset=0 SHALL immediately force state=BOOT, pc=0, pc_valid=0, flush=0, pending=0, misaligned=0, captured target=0, independent of clk.
REQ-024 Reset mid-HOLD SHALL discard the captured redirect; no flush after release.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs redirect_cnt[31:0] (increments per applied redirect) and stall_cnt[31:0] (increments per cycle with stall=1 in RUN/HOLD); both wrap, reset to 0.
REQ-026 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package fetch_pkg SHALL hold the state enum (BOOT, RUN, HOLD) and constant PC_INC=4.
REQ-028 Counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-029 Reset release, stall=0, no redirect, 4 cycles -> pc 0,0,4,8,12; pc_valid=1 from first edge; flush=0 throughout.
REQ-030 RUN at pc=0x10, redirect=1, redirect_pc=0x40 one cycle -> next pc=0x40, flush=1 exactly one cycle, misaligned=0.
REQ-031 stall=1 with redirect=1, redirect_pc=0x80 then redirect_pc=0x90, stall held 3 cycles -> pc frozen, pending=1; on release pc=0x80, flush pulse, pending=0.
REQ-032 PC_W=9, pc=0x1FC, no stall -> next pc=0x000 (wrap), no flush.
REQ-033 redirect_pc=0x00000123 -> pc=0x120, flush=1 and misaligned=1 same cycle; with macro defined redirect_cnt increments by 1.
REQ-034 reset asserted while pending=1 -> all outputs 0 immediately; after release BOOT sequence of REQ-029, no flush.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC unit.
// Contents: FSM state enum (BOOT, RUN, HOLD) and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters. Only instantiated when FETCH_PERF_CNT_EN is defined.
// Ports:
//   clk_i            - clock
//   rst_ni           - asynchronous active-low reset
//   redirect_apply_i - a redirect is applied to the PC on this edge
//   stall_i          - fetch is frozen this cycle (outside BOOT)
//   redirect_cnt_o   - applied redirect count, wraps
//   stall_cnt_o      - stalled cycle count, wraps
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_apply_i,
  input  logic        stall_i,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_apply_i ? redirect_cnt_q + 32'd1 : redirect_cnt_q;
    stall_cnt_d    = stall_i ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with stall freeze, branch redirect and deferred redirect
// capture while stalled. All outputs are registered.
// Optional feature macro: FETCH_PERF_CNT_EN adds redirect_cnt / stall_cnt.
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-low reset
//   stall       - hazard freeze of the fetch PC
//   redirect    - branch/jump taken
//   redirect_pc - taken target; bits above PC_W-1 ignored
//   pc          - current fetch address
//   pc_valid    - pc is fetchable
//   flush       - one-cycle pulse killing IF/ID and ID/EX
//   pending     - a redirect is captured, waiting for stall release
//   misaligned  - one-cycle pulse with flush when the applied target had bits [1:0] != 0
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            pending,
  output logic            misaligned
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] tgt_q;

  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[31:PC_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc         <= '0;
      pc_valid   <= 1'b0;
      flush      <= 1'b0;
      pending    <= 1'b0;
      misaligned <= 1'b0;
      tgt_q      <= '0;
    end else begin
      // Pulses default low so each applied redirect yields exactly one cycle.
      flush      <= 1'b0;
      misaligned <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q  <= RUN;
          pc_valid <= 1'b1;
          pc       <= '0;
        end
        RUN: begin
          if (!stall) begin
            if (redirect) begin
              pc         <= {redirect_pc[PC_W-1:2], 2'b00};
              flush      <= 1'b1;
              misaligned <= |redirect_pc[1:0];
            end else begin
              pc <= pc + PC_W'(PC_INC);
            end
          end else if (redirect) begin
            tgt_q   <= redirect_pc[PC_W-1:0];
            pending <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Captured target wins; live redirect inputs are ignored here.
          if (!stall) begin
            pc         <= {tgt_q[PC_W-1:2], 2'b00};
            flush      <= 1'b1;
            misaligned <= |tgt_q[1:0];
            pending    <= 1'b0;
            state_q    <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic redirect_apply;
  logic stall_count_en;

  always_comb begin
    redirect_apply = ((state_q == RUN) && !stall && redirect) ||
                     ((state_q == HOLD) && !stall);
    stall_count_en = stall && (state_q != BOOT);
  end

  fetch_perf_cnt u_perf_cnt (
    .clk_i            (clk),
    .rst_ni           (reset),
    .redirect_apply_i (redirect_apply),
    .stall_i          (stall_count_en),
    .redirect_cnt_o   (redirect_cnt),
    .stall_cnt_o      (stall_cnt)
  );
`endif

endmodule
